level_countdown_timer: RTL and testbench
========================================

// Module: level_countdown_timer
// PURPOSE
//   Per-level countdown timer downstream of the game-state FSM. Loads the two-digit BCD start
//   time (startTimeLEFT/startTimeRIGHT) when the FSM pulses update and counts down once per second.
//   Drives the time digits to the display and produces the timeout pulse that feeds the FSM fail input.
//   Holds the displayed value when the game halts on a win or a fail.
// PARAMETERS
//   TICK_DIV  100_000_000  clk cycles per one-second tick (>=2); small values (e.g. 4) for simulation
// PORTS
//   clk             in   1  system clock, all logic on posedge
//   reset           in   1  asynchronous, active-low reset (0 = reset)
//   load            in   1  load strobe (FSM update); samples start digits this cycle
//   startTimeLEFT   in   4  start tens digit, BCD
//   startTimeRIGHT  in   4  start ones digit, BCD
//   halt            in   1  freeze request (FSM failState | winState), level-sensitive
//   timeLEFT        out  4  current tens digit, BCD
//   timeRIGHT       out  4  current ones digit, BCD
//   running         out  1  1 while in RUN
//   tick            out  1  1-cycle pulse on each second decrement
//   timeout         out  1  1-cycle pulse when count reaches 00 from RUN (to FSM fail)
// BEHAVIOUR
// - Reset (reset==0, async): state IDLE, prescaler 0, timeLEFT=timeRIGHT=0, running=tick=timeout=0.
// - All outputs are registered. States: IDLE, RUN, EXPIRED.
// - Digit clamp: any sampled start digit >9 is loaded as 9.
// - load=1, any state: digits <= clamped inputs next edge, prescaler <= 0. If loaded value is 00:
//   next state IDLE with no timeout pulse; otherwise next state RUN. load has priority over halt and tick.
// - RUN: prescaler counts 0..TICK_DIV-1 and wraps. On the edge where it wraps, tick=1 for one cycle
//   and the count decrements in BCD: RIGHT>0 -> RIGHT-1; RIGHT==0 -> RIGHT=9, LEFT-1.
//   First decrement occurs TICK_DIV cycles after the load edge.
// - Reaching 00 in RUN: timeout=1 for exactly that cycle (same cycle as tick). Next state EXPIRED.
//   Digits stay 00.
// - halt=1 in RUN without load: next state IDLE, digits frozen, prescaler <= 0, no tick and no timeout.
//   If halt and a wrap occur in the same cycle, halt wins and no decrement occurs.
// - IDLE/EXPIRED: digits hold, prescaler held at 0, running=0. Only load leaves these states.
// - running is 1 iff state==RUN. timeout never asserts outside the RUN->EXPIRED transition.
// - Prescaler width is $clog2(TICK_DIV). Digit arithmetic is 4-bit BCD only; no binary wrap past 0.
// - Asserting reset mid-count returns to IDLE immediately, asynchronously. First edge after
//   release behaves as IDLE.
// TESTING (TICK_DIV=4)
// - load 9,0 -> running=1; after 4 cycles tick and 8,9; after 8 cycles 8,8; no timeout.
// - load 0,2 -> 0,1 at cycle 4; 0,0 with tick=timeout=1 for one cycle at cycle 8; EXPIRED, digits hold 00.
// - load 0,0 (FSM START strobe) -> IDLE, running=0, timeout never pulses over 20 cycles.
// - load 6,0, halt=1 at cycle 6 -> digits freeze at 5,9, running=0; a new load 3,0 restarts RUN at 3,0.
// - load 1,2 asserted on the cycle of a wrap -> digits 1,2, prescaler cleared, next tick 4 cycles later.
// - reset=0 mid-RUN at 5,7 -> outputs 0 at once (async); load 15,12 -> digits clamp to 9,9.

Source files
------------

// File: rtl/level_countdown_timer.sv
// Per-level two-digit BCD countdown: loads a start time, decrements once per TICK_DIV cycles,
// pulses timeout on reaching 00 and freezes the display on halt.
module level_countdown_timer #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] startTimeLEFT,
  input  logic [3:0] startTimeRIGHT,
  input  logic       halt,
  output logic [3:0] timeLEFT,
  output logic [3:0] timeRIGHT,
  output logic       running,
  output logic       tick,
  output logic       timeout
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      left_q, left_d;
  logic [3:0]      right_q, right_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;
  logic            timeout_q, timeout_d;
  logic [3:0]      load_left, load_right;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit);
    return (digit > 4'd9) ? 4'd9 : digit;
  endfunction

  assign load_left  = clamp_bcd(startTimeLEFT);
  assign load_right = clamp_bcd(startTimeRIGHT);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    left_d    = left_q;
    right_d   = right_q;
    tick_d    = 1'b0;
    timeout_d = 1'b0;

    // load overrides halt and any pending wrap in every state
    if (load) begin
      left_d  = load_left;
      right_d = load_right;
      presc_d = '0;
      state_d = (load_left == 4'd0 && load_right == 4'd0) ? ST_IDLE : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (right_q != 4'd0) begin
              right_d = right_q - 4'd1;
            end else begin
              right_d = 4'd9;
              left_d  = left_q - 4'd1;
            end
            if (left_q == 4'd0 && right_q == 4'd1) begin
              timeout_d = 1'b1;
              state_d   = ST_EXPIRED;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: presc_d = '0;
      endcase
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      left_q    <= 4'd0;
      right_q   <= 4'd0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      left_q    <= left_d;
      right_q   <= right_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeLEFT  = left_q;
  assign timeRIGHT = right_q;
  assign running   = running_q;
  assign tick      = tick_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_level_countdown_timer.sv
// Directed bench for level_countdown_timer with TICK_DIV=4: load, countdown, expiry,
// halt, load-on-wrap priority, async reset and digit clamping.
module tb_level_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [3:0] startTimeLEFT = 4'd0;
  logic [3:0] startTimeRIGHT = 4'd0;
  logic       halt = 1'b0;
  logic [3:0] timeLEFT;
  logic [3:0] timeRIGHT;
  logic       running;
  logic       tick;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  level_countdown_timer #(.TICK_DIV(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .startTimeLEFT  (startTimeLEFT),
    .startTimeRIGHT (startTimeRIGHT),
    .halt           (halt),
    .timeLEFT       (timeLEFT),
    .timeRIGHT      (timeRIGHT),
    .running        (running),
    .tick           (tick),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle load; returns just after the load edge (cycle 0).
  task automatic do_load(input logic [3:0] l, input logic [3:0] r);
    load = 1'b1;
    startTimeLEFT = l;
    startTimeRIGHT = r;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    checks++;
    if ({timeLEFT, timeRIGHT, running, tick, timeout} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got L=%0d R=%0d run=%b tick=%b to=%b, need all 0",
               timeLEFT, timeRIGHT, running, tick, timeout);
    end
    reset = 1'b1;
    step();
    checks++;
    if (running !== 1'b0 || timeLEFT !== 4'd0 || timeRIGHT !== 4'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got L=%0d R=%0d run=%b, need 0 0 0", timeLEFT, timeRIGHT, running);
    end
  endtask

  task automatic test_countdown_borrow();
    int to_seen = 0;
    do_load(4'd9, 4'd0);
    checks++;
    if (running !== 1'b1 || timeLEFT !== 4'd9 || timeRIGHT !== 4'd0) begin
      errors++;
      $display("FAIL load_90: got L=%0d R=%0d run=%b, need 9 0 1", timeLEFT, timeRIGHT, running);
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      if (timeout) to_seen++;
      if (k == 3) begin
        checks++;
        if (tick !== 1'b0 || timeRIGHT !== 4'd0) begin
          errors++;
          $display("FAIL early_tick: got tick=%b R=%0d at cycle 3, need 0 0", tick, timeRIGHT);
        end
      end
      if (k == 4) begin
        checks++;
        if (tick !== 1'b1 || timeLEFT !== 4'd8 || timeRIGHT !== 4'd9) begin
          errors++;
          $display("FAIL first_tick: got tick=%b L=%0d R=%0d, need 1 8 9", tick, timeLEFT, timeRIGHT);
        end
      end
      if (k == 8) begin
        checks++;
        if (tick !== 1'b1 || timeLEFT !== 4'd8 || timeRIGHT !== 4'd8) begin
          errors++;
          $display("FAIL second_tick: got tick=%b L=%0d R=%0d, need 1 8 8", tick, timeLEFT, timeRIGHT);
        end
      end
    end
    checks++;
    if (to_seen != 0) begin
      errors++;
      $display("FAIL no_timeout_90: got %0d timeout pulses, need 0", to_seen);
    end
    $display("countdown 9,0 -> %0d,%0d running=%b", timeLEFT, timeRIGHT, running);
  endtask

  task automatic test_expire();
    do_load(4'd0, 4'd2);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (timeLEFT !== 4'd0 || timeRIGHT !== 4'd1 || timeout !== 1'b0 || running !== 1'b1) begin
          errors++;
          $display("FAIL expire_01: got L=%0d R=%0d to=%b run=%b, need 0 1 0 1",
                   timeLEFT, timeRIGHT, timeout, running);
        end
      end
      if (k == 8) begin
        checks++;
        if (timeLEFT !== 4'd0 || timeRIGHT !== 4'd0 || tick !== 1'b1 || timeout !== 1'b1) begin
          errors++;
          $display("FAIL expire_00: got L=%0d R=%0d tick=%b to=%b, need 0 0 1 1",
                   timeLEFT, timeRIGHT, tick, timeout);
        end
      end
      if (k == 9) begin
        checks++;
        if (timeout !== 1'b0 || tick !== 1'b0 || running !== 1'b0 || timeRIGHT !== 4'd0) begin
          errors++;
          $display("FAIL expired_hold: got to=%b tick=%b run=%b R=%0d, need 0 0 0 0",
                   timeout, tick, running, timeRIGHT);
        end
      end
    end
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (timeLEFT !== 4'd0 || timeRIGHT !== 4'd0 || running !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL expired_stay: got L=%0d R=%0d run=%b to=%b, need 0 0 0 0",
               timeLEFT, timeRIGHT, running, timeout);
    end
    $display("expire 0,2 -> %0d,%0d running=%b", timeLEFT, timeRIGHT, running);
  endtask

  task automatic test_load_zero();
    int pulses = 0;
    do_load(4'd0, 4'd0);
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL load_00_running: got %b, need 0", running);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (timeout || tick || running) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL load_00_quiet: got %0d active cycles, need 0", pulses);
    end
    $display("load 0,0 -> running=%b", running);
  endtask

  task automatic test_halt();
    do_load(4'd6, 4'd0);
    for (int k = 1; k <= 5; k++) step();
    halt = 1'b1;
    step();
    checks++;
    if (timeLEFT !== 4'd5 || timeRIGHT !== 4'd9 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_freeze: got L=%0d R=%0d run=%b, need 5 9 0", timeLEFT, timeRIGHT, running);
    end
    for (int k = 0; k < 6; k++) step();
    checks++;
    if (timeLEFT !== 4'd5 || timeRIGHT !== 4'd9 || tick !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got L=%0d R=%0d tick=%b, need 5 9 0", timeLEFT, timeRIGHT, tick);
    end
    halt = 1'b0;
    do_load(4'd3, 4'd0);
    checks++;
    if (timeLEFT !== 4'd3 || timeRIGHT !== 4'd0 || running !== 1'b1) begin
      errors++;
      $display("FAIL halt_reload: got L=%0d R=%0d run=%b, need 3 0 1", timeLEFT, timeRIGHT, running);
    end
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (timeLEFT !== 4'd2 || timeRIGHT !== 4'd9 || tick !== 1'b1) begin
      errors++;
      $display("FAIL halt_reload_tick: got L=%0d R=%0d tick=%b, need 2 9 1", timeLEFT, timeRIGHT, tick);
    end
    // halt arriving on a wrap edge must suppress the decrement
    do_load(4'd4, 4'd4);
    for (int k = 1; k <= 3; k++) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if (timeLEFT !== 4'd4 || timeRIGHT !== 4'd4 || tick !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_on_wrap: got L=%0d R=%0d tick=%b run=%b, need 4 4 0 0",
               timeLEFT, timeRIGHT, tick, running);
    end
    $display("halt -> %0d,%0d running=%b", timeLEFT, timeRIGHT, running);
  endtask

  task automatic test_load_on_wrap();
    int early = 0;
    do_load(4'd5, 4'd0);
    for (int k = 1; k <= 3; k++) step();
    do_load(4'd1, 4'd2);
    checks++;
    if (timeLEFT !== 4'd1 || timeRIGHT !== 4'd2 || tick !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_wrap: got L=%0d R=%0d tick=%b run=%b, need 1 2 0 1",
               timeLEFT, timeRIGHT, tick, running);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      if (tick) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL load_wrap_presc: got %0d early ticks, need 0", early);
    end
    step();
    checks++;
    if (tick !== 1'b1 || timeLEFT !== 4'd1 || timeRIGHT !== 4'd1) begin
      errors++;
      $display("FAIL load_wrap_tick: got tick=%b L=%0d R=%0d, need 1 1 1", tick, timeLEFT, timeRIGHT);
    end
    $display("load on wrap 1,2 -> %0d,%0d", timeLEFT, timeRIGHT);
  endtask

  task automatic test_async_reset_clamp();
    do_load(4'd5, 4'd8);
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (timeLEFT !== 4'd5 || timeRIGHT !== 4'd7) begin
      errors++;
      $display("FAIL pre_reset: got L=%0d R=%0d, need 5 7", timeLEFT, timeRIGHT);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({timeLEFT, timeRIGHT, running, tick, timeout} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got L=%0d R=%0d run=%b tick=%b to=%b, need all 0",
               timeLEFT, timeRIGHT, running, tick, timeout);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (running !== 1'b0 || timeLEFT !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_idle: got run=%b L=%0d, need 0 0", running, timeLEFT);
    end
    do_load(4'd15, 4'd12);
    checks++;
    if (timeLEFT !== 4'd9 || timeRIGHT !== 4'd9 || running !== 1'b1) begin
      errors++;
      $display("FAIL clamp: got L=%0d R=%0d run=%b, need 9 9 1", timeLEFT, timeRIGHT, running);
    end
    $display("reset+clamp -> %0d,%0d running=%b", timeLEFT, timeRIGHT, running);
  endtask

  initial begin
    test_reset();
    test_countdown_borrow();
    test_expire();
    test_load_zero();
    test_halt();
    test_load_on_wrap();
    test_async_reset_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
